mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles in BUSY without m_ack before the transaction is aborted.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 i_req  input  1  instruction-side read request, held until i_ack.
REQ-005 i_addr  input  32  instruction-side address.
REQ-006 i_dout  output  32  instruction read data, valid while i_ack=1.
REQ-007 i_ack  output  1  one-cycle completion pulse; i_stall  output  1  = i_req & ~i_ack (combinational).
REQ-008 d_ren, d_wen  input  1 each  data-side read/write request, held until d_ack.
REQ-009 d_addr, d_din  input  32 each  data-side address and write data.
REQ-010 d_dout  output  32  data read data, valid while d_ack=1.
REQ-011 d_ack  output  1  one-cycle pulse; d_stall  output  1  = (d_ren|d_wen) & ~d_ack (combinational).
REQ-012 m_addr, m_din  output  32 each; m_ren, m_wen  output  1 each: shared slow-memory request.
REQ-013 m_dout  input  32; m_ack  input  1: memory read data and completion.
REQ-014 err  output  1  sticky timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE: no request -> stay; one side requesting -> grant it, go BUSY; both -> grant side opposite to last_grant, go BUSY.
REQ-017 On grant, addr, din and operation SHALL be latched; m_* driven only from latched registers, stable for the whole BUSY state.
REQ-018 d_ren & d_wen both 1 SHALL be treated as a write; I-side SHALL only read.
REQ-019 BUSY: m_ren/m_wen asserted per latched op; m_ack sampled 1 at posedge -> latch m_dout (reads; 0 for writes), go DONE.
REQ-020 DONE: m_ren=m_wen=0 for exactly one cycle (memory recovery gap); granted side's ack=1 and dout=latched data; next state IDLE.
REQ-021 Ack and dout of the non-granted side SHALL be 0 in every cycle.
REQ-022 Latency: request at IDLE posedge t -> m_* valid from t+1; requester ack exactly 1 cycle after the posedge sampling m_ack.
REQ-023 last_grant SHALL update on every grant; reset value D, so first contention goes to I.
REQ-024 Timeout counter SHALL clear on entering BUSY, increment per BUSY cycle; reaching TIMEOUT -> go DONE with dout=0, ack pulsed, err set.
REQ-025 err SHALL remain 1 until reset.
REQ-026 Request withdrawn during BUSY SHALL NOT abort the transaction; ack still pulses in DONE.
REQ-027 m_ack while not in BUSY SHALL be ignored.
REQ-028 A requester still asserting in the cycle after its ack is a new request, arbitrated normally.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, m_ren=m_wen=0, m_addr=m_din=0, i_ack=d_ack=0, i_dout=d_dout=0, err=0, counter=0, last_grant=D.
REQ-030 Reset mid-BUSY SHALL drop the transaction with no ack; requesters re-arbitrate after release.

Structure
REQ-031 State encoding and default TIMEOUT SHALL live in a shared package with the memory-side constants.
REQ-032 No sub-module; FSM, arbiter and counter SHALL reside in mem_arbiter.

Verification
REQ-033 I read 0x4, memory acks after 8 BUSY cycles with 0xDEADBEEF -> i_ack pulses one cycle later, i_dout=0xDEADBEEF, d_ack=0.
REQ-034 D write 0x8/0x12345678 -> m_wen=1, m_addr=0x8, m_din=0x12345678 stable until m_ack; d_ack pulse; m_wen=0 in DONE.
REQ-035 I and D requesting simultaneously from reset -> I served first, D next; repeated contention alternates I, D, I, D.
REQ-036 d_ren=d_wen=1 -> write performed, m_ren=0.
REQ-037 m_ack never asserted, TIMEOUT=64 -> ack after 64 BUSY cycles with dout=0, err=1 and held until reset.
REQ-038 rst=0 mid-BUSY -> m_ren=0 immediately, no ack; after release, held request re-granted and completes.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port slow-memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int TIMEOUT_DEFAULT = 64;

    localparam logic [ADDR_W-1:0] MEM_ADDR_IDLE = '0;
    localparam logic [DATA_W-1:0] MEM_DATA_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Under contention the side that did not win last time goes first.
    function automatic side_t pick_side(input logic i_want, input logic d_want,
                                        input side_t last);
        if (i_want && d_want)
            return (last == SIDE_D) ? SIDE_I : SIDE_D;
        else if (i_want)
            return SIDE_I;
        else
            return SIDE_D;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data ports onto one slow memory, with a
// per-transaction timeout and a sticky error flag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_dout,
    output logic              i_ack,
    output logic              i_stall,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_din,
    output logic [DATA_W-1:0] d_dout,
    output logic              d_ack,
    output logic              d_stall,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    output logic              m_ren,
    output logic              m_wen,
    input  logic [DATA_W-1:0] m_dout,
    input  logic              m_ack,
    output logic              err
);

    // state | meaning
    // IDLE  | no transaction; arbitrate pending requests
    // BUSY  | latched request on memory bus, waiting for m_ack or timeout
    // DONE  | one-cycle ack to granted side; memory bus quiet (recovery gap)

    localparam int          CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t              state, state_nxt;
    side_t               grant_q, last_grant, side_sel;
    op_t                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic [DATA_W-1:0]   data_q;
    logic [CW-1:0]       count;
    logic                d_req;
    logic                take;
    logic                hit;
    logic                expire;

    assign d_req = d_ren | d_wen;

    always_comb begin
        state_nxt = state;
        side_sel  = SIDE_I;
        take      = 1'b0;
        hit       = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    take      = 1'b1;
                    side_sel  = pick_side(i_req, d_req, last_grant);
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ack) begin
                    hit       = 1'b1;
                    state_nxt = ST_DONE;
                end else if (count == LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant_q    <= SIDE_I;
            last_grant <= SIDE_D;
            op_q       <= OP_READ;
            addr_q     <= MEM_ADDR_IDLE;
            din_q      <= MEM_DATA_NONE;
            data_q     <= MEM_DATA_NONE;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                grant_q    <= side_sel;
                last_grant <= side_sel;
                count      <= '0;
                if (side_sel == SIDE_D) begin
                    // Simultaneous read+write from the data side is a write.
                    op_q   <= d_wen ? OP_WRITE : OP_READ;
                    addr_q <= d_addr;
                    din_q  <= d_wen ? d_din : MEM_DATA_NONE;
                end else begin
                    op_q   <= OP_READ;
                    addr_q <= i_addr;
                    din_q  <= MEM_DATA_NONE;
                end
            end else if (state == ST_BUSY) begin
                count <= count + CW'(1);
                if (hit) begin
                    data_q <= (op_q == OP_READ) ? m_dout : MEM_DATA_NONE;
                end else if (expire) begin
                    data_q <= MEM_DATA_NONE;
                    err    <= 1'b1;
                end
            end
        end
    end

    assign m_addr = addr_q;
    assign m_din  = din_q;
    assign m_ren  = (state == ST_BUSY) && (op_q == OP_READ);
    assign m_wen  = (state == ST_BUSY) && (op_q == OP_WRITE);

    assign i_ack  = (state == ST_DONE) && (grant_q == SIDE_I);
    assign d_ack  = (state == ST_DONE) && (grant_q == SIDE_D);
    assign i_dout = i_ack ? data_q : MEM_DATA_NONE;
    assign d_dout = d_ack ? data_q : MEM_DATA_NONE;

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

endmodule
